// File: rtl/key_loader_pkg.sv
// Shared lock package: key loader state encoding and default sizing constants.
package key_loader_pkg;

  localparam int KEY_W_DEF    = 8;
  localparam int MAX_FAIL_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_LOCKED,
    ST_LOCKOUT
  } state_e;

endpackage

// File: rtl/key_loader_parity_acc.sv
// Running even-parity accumulator: XOR of every bit enabled since the last clear.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic parity
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         parity <= 1'b0;
    else if (clr)    parity <= 1'b0;
    else if (en)     parity <= parity ^ bit_in;
  end

endmodule

// File: rtl/key_loader.sv
// Serial key loader: shifts KEY_W key bits plus an even-parity bit, verifies them,
// and presents the verified key to the locked FSM; repeated failures lock out.
//
// Handshake: a serial bit transfers on a rising edge where ser_valid and ser_ready
// are both 1; ser_ready is 1 only in SHIFT, and ser_valid may drop for any number
// of cycles without losing data.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic             ser_data,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             lockout,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int CNT_W  = $clog2(KEY_W + 2);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  state_e             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [KEY_W-1:0]   shadow;
  logic [1:0]         rst_sync;
  logic               rst_i;
  logic               xfer;
  logic               start;
  logic               parity;

  // Assert asynchronously, release two clock edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  assign xfer      = ser_valid & ser_ready;
  assign start     = load_req & ((state == ST_IDLE) | (state == ST_LOCKED));
  assign dbg_state = state;

  parity_acc u_parity (
    .clk    (clk),
    .rst    (rst_i),
    .clr    (start),
    .en     (xfer),
    .bit_in (ser_data),
    .parity (parity)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      fail_cnt  <= '0;
      shadow    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
      lockout   <= 1'b0;
      busy      <= 1'b0;
      ser_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_LOCKED: begin
          if (load_req) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            shadow    <= '0;
            load_err  <= 1'b0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
            ser_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            bit_cnt <= bit_cnt + 1'b1;
            // The transfer after the last key bit is the parity bit.
            if (bit_cnt == CNT_W'(KEY_W)) begin
              state     <= ST_CHECK;
              ser_ready <= 1'b0;
            end else begin
              shadow <= {ser_data, shadow[KEY_W-1:1]};
            end
          end
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (!parity) begin
            state     <= ST_LOCKED;
            key_out   <= shadow;
            key_valid <= 1'b1;
            fail_cnt  <= '0;
          end else begin
            key_out  <= '0;
            load_err <= 1'b1;
            if (fail_cnt >= FAIL_W'(MAX_FAIL - 1)) begin
              state    <= ST_LOCKOUT;
              lockout  <= 1'b1;
              fail_cnt <= FAIL_W'(MAX_FAIL);
            end else begin
              state    <= ST_IDLE;
              fail_cnt <= fail_cnt + 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          key_out   <= '0;
          key_valid <= 1'b0;
          lockout   <= 1'b1;
          busy      <= 1'b0;
          ser_ready <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed and randomized checks of key_loader against a load-level reference model.
module tb_key_loader;
  import key_loader_pkg::*;

  localparam int KW = 8;
  localparam int MF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          ser_data = 1'b0;
  logic          ser_valid = 1'b0;
  logic          ser_ready;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          load_err;
  logic          lockout;
  logic          busy;
  state_e        dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outcome of whole loads, not cycle-level registers.
  logic [KW-1:0] m_key;
  logic          m_valid, m_err, m_lock;
  int            m_fails;
  state_e        m_state;
  logic [KW-1:0] exp_q[$];

  always #5 clk = ~clk;

  key_loader #(.KEY_W(KW), .MAX_FAIL(MF)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .load_err  (load_err),
    .lockout   (lockout),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".key_out"},   32'(key_out),   32'(m_key));
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
    chk({tag, ".load_err"},  32'(load_err),  32'(m_err));
    chk({tag, ".lockout"},   32'(lockout),   32'(m_lock));
    chk({tag, ".busy"},      32'(busy),      32'(m_state == ST_SHIFT || m_state == ST_CHECK));
    chk({tag, ".ser_ready"}, 32'(ser_ready), 32'(m_state == ST_SHIFT));
    chk({tag, ".state"},     32'(dbg_state), 32'(m_state));
  endtask

  task automatic model_reset;
    m_key = '0; m_valid = 1'b0; m_err = 1'b0; m_lock = 1'b0;
    m_fails = 0; m_state = ST_IDLE;
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; load_req = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    #1;
    model_reset();
    chk_all({tag, ".assert"});
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk_all({tag, ".release"});
  endtask

  task automatic start_load(input string tag);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    if (m_state == ST_IDLE || m_state == ST_LOCKED) begin
      m_state = ST_SHIFT; m_valid = 1'b0; m_err = 1'b0;
    end
    chk_all({tag, ".start"});
  endtask

  // mode 0: continuous valid, 1: toggling valid, 2: random gaps plus stray load_req
  task automatic feed(input logic [KW-1:0] key, input logic par, input int mode,
                      input int nbits, output int accepted, output int cycles);
    int idx = 0;
    int cyc = 0;
    logic tog = 1'b1;
    logic v;
    while (idx < nbits && cyc < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      ser_valid = v;
      ser_data  = (idx < KW) ? key[idx] : par;
      load_req  = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (ser_ready && v) idx++;
      tick();
      cyc++;
    end
    ser_valid = 1'b0; ser_data = 1'b0; load_req = 1'b0;
    accepted = idx;
    cycles = cyc;
  endtask

  task automatic model_result(input logic [KW-1:0] key, input logic par);
    if ((^key ^ par) == 1'b0) begin
      m_key = key; m_valid = 1'b1; m_err = 1'b0; m_fails = 0; m_state = ST_LOCKED;
    end else begin
      m_fails = (m_fails + 1 > MF) ? MF : m_fails + 1;
      m_key = '0; m_valid = 1'b0; m_err = 1'b1;
      if (m_fails == MF) begin
        m_lock = 1'b1; m_state = ST_LOCKOUT;
      end else begin
        m_state = ST_IDLE;
      end
    end
    exp_q.push_back(m_key);
  endtask

  task automatic full_load(input logic [KW-1:0] key, input logic par, input int mode,
                           input string tag, output int cycles);
    int acc;
    int cyc;
    start_load(tag);
    feed(key, par, mode, KW + 1, acc, cyc);
    chk({tag, ".xfers"}, 32'(acc), 32'(KW + 1));
    m_state = ST_CHECK;
    ser_valid = 1'b1;
    chk_all({tag, ".check"});
    tick();
    ser_valid = 1'b0;
    model_result(key, par);
    chk_all({tag, ".done"});
    chk({tag, ".key_sb"}, 32'(key_out), 32'(exp_q.pop_front()));
    cycles = 1 + cyc + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acc;
    logic [KW-1:0] rkey;
    logic          rpar;

    do_reset("reset");

    // Good load with continuous valid: result lands 11 cycles after load_req.
    full_load(8'hA5, 1'b0, 0, "good_a5", cyc);
    chk("good_a5.latency", 32'(cyc), 32'd11);

    // Reload from LOCKED.
    full_load(8'h0F, 1'b0, 0, "reload_0f", cyc);

    // Bad parity from LOCKED, then two more failures to lock out.
    full_load(8'hA5, 1'b1, 0, "bad1", cyc);
    full_load(8'h01, 1'b0, 0, "bad2", cyc);
    full_load(8'hFF, 1'b1, 1, "bad3", cyc);

    // Load attempts in LOCKOUT change nothing.
    load_req = 1'b1; ser_valid = 1'b1; ser_data = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_all("lockout_hold");
      tick();
    end
    ser_valid = 1'b0;

    // Reset mid-load with residue that would corrupt both key and parity.
    do_reset("reset2");
    start_load("abort");
    feed(8'hF7, 1'b0, 0, 4, acc, cyc);
    chk("abort.xfers", 32'(acc), 32'd4);
    do_reset("reset_mid");
    full_load(8'h3C, 1'b0, 0, "after_abort", cyc);

    // Toggling valid: 9 accepted transfers spread over 17 cycles.
    full_load(8'h5A, 1'b0, 1, "toggle_5a", cyc);
    chk("toggle_5a.latency", 32'(cyc), 32'd19);

    // Random loads with random gaps, mostly good parity.
    for (int n = 0; n < 30; n++) begin
      if (m_state == ST_LOCKOUT) do_reset("rand_reset");
      rkey = KW'($urandom);
      rpar = ($urandom_range(0, 3) == 0) ? ~(^rkey) : ^rkey;
      full_load(rkey, rpar, $urandom_range(0, 2), "rand", cyc);
      repeat ($urandom_range(0, 3)) tick();
      chk_all("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 8: number of key bits delivered to the locked FSM, keyinput0 upward, LSB = keyinput0.
REQ-002 Parameter MAX_FAIL, default 3: failed load attempts before permanent lockout.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_req  input  1  single-cycle request to start a key load.
REQ-006 ser_data  input  1  serial key/parity bit.
REQ-007 ser_valid  input  1  ser_data valid this cycle.
REQ-008 ser_ready  output  1  block accepts a serial bit this cycle.
REQ-009 key_out  output  KEY_W  key bits to the locked FSM.
REQ-010 key_valid  output  1  key_out holds a verified key.
REQ-011 load_err  output  1  last attempt failed parity.
REQ-012 lockout  output  1  MAX_FAIL failures reached.
REQ-013 busy  output  1  load in progress.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, CHECK, LOCKED and LOCKOUT, all registered.
REQ-015 A serial bit SHALL transfer only on a cycle where ser_valid=1 and ser_ready=1; ser_ready=1 only in SHIFT.
REQ-016 load_req in IDLE or LOCKED SHALL enter SHIFT next cycle, clearing the bit counter and load_err and dropping key_valid; it SHALL be ignored in SHIFT, CHECK and LOCKOUT.
REQ-017 In SHIFT, the first KEY_W transfers SHALL fill a shadow register LSB first, and transfer KEY_W+1 SHALL be the parity bit; the FSM SHALL move to CHECK the cycle after the parity transfer.
REQ-018 CHECK SHALL last exactly one cycle with ser_ready=0; pass = XOR of the shadow bits and the parity bit equals 0 (even parity).
REQ-019 On pass, the FSM SHALL enter LOCKED, copy the shadow register to key_out, set key_valid=1 and clear the fail counter.
REQ-020 On fail, the fail counter SHALL increment and load_err SHALL be set; at MAX_FAIL the FSM SHALL enter LOCKOUT, otherwise IDLE; key_out SHALL be zero after any fail.
REQ-021 LOCKOUT SHALL be absorbing until rst: lockout=1, key_out=0, key_valid=0, ser_ready=0.
REQ-022 key_out SHALL change only on CHECK exit, on a fail, or on reset; it SHALL stay stable throughout LOCKED.
REQ-023 busy SHALL equal 1 in SHIFT and CHECK.
REQ-024 Gaps in ser_valid during SHIFT SHALL stall the load indefinitely without timeout or loss of data.
REQ-025 The bit counter SHALL be ceil(log2(KEY_W+2)) bits wide and SHALL NOT wrap within a load; the fail counter SHALL saturate at MAX_FAIL.

Reset
REQ-026 rst SHALL force IDLE immediately, including mid-load, discarding partial shift data.
REQ-027 Reset values: key_out=0, key_valid=0, load_err=0, lockout=0, busy=0, ser_ready=0, fail counter=0, bit counter=0.
REQ-028 Release from rst SHALL be synchronous to clk via the standard reset synchronizer.

Structure
REQ-029 The state encoding enum and the default KEY_W/MAX_FAIL constants SHALL live in the shared lock package.
REQ-030 An even-parity accumulator SHALL be a separate sub-module, parity_acc: clear, enable and bit in, running parity out.
REQ-031 key_out SHALL drive the keyinput ports of the locked FSM directly, with no further logic.

Verification
REQ-032 KEY_W=8: load_req, bits 0xA5 LSB first, parity 0, continuous ser_valid -> key_valid=1 and key_out=0xA5 exactly 11 cycles after load_req; load_err=0.
REQ-033 Bits 0xA5 with parity 1 -> load_err=1, key_out=0x00, FSM in IDLE, fail counter=1.
REQ-034 Three consecutive bad-parity loads -> lockout=1 after the third CHECK; a fourth load_req produces ser_ready=0 and no change on any output.
REQ-035 rst asserted after 4 of 8 data bits, then released and 0x3C loaded with parity 0 -> key_out=0x3C, with no residue from the aborted load.
REQ-036 ser_valid toggled 1/0 every cycle during 0x5A, parity 0 -> exactly 9 transfers accepted and key_out=0x5A.
REQ-037 load_req while LOCKED with 0xA5, then 0x0F loaded with parity 0 -> key_valid=0 during reload, then key_out=0x0F, key_valid=1.
